// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises a 32-bit word as four 8N1 UART frames.
// Bytes go out least-significant first, and each byte is sent LSB first.
// An optional idle-high gap can be placed between the frames of one word.
// The line, busy and done outputs all come straight from registers.

module uart_word_tx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int GAP_CLKS     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] word_in,
    input  logic        send,
    output logic        uart_out,
    output logic        busy,
    output logic        done
);

    // One counter times both bit periods and gaps, so size it for the longer.
    localparam int MAX_CNT = (CLKS_PER_BIT > GAP_CLKS) ? CLKS_PER_BIT : GAP_CLKS;
    localparam int CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CLKS > 0) ? CNT_W'(GAP_CLKS - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_clk_cnt;
    logic [2:0]         r_bit_idx;
    logic [1:0]         r_byte_idx;
    logic [31:0]        r_shift;
    logic               r_uart;
    logic               r_busy;
    logic               r_done;

    logic               w_bit_end;
    logic               w_gap_end;
    logic [7:0]         w_byte;

    // The byte in flight always sits in the low eight bits of the shift register.
    assign w_byte    = r_shift[7:0];
    assign w_bit_end = (r_clk_cnt == BIT_LAST);
    assign w_gap_end = (r_clk_cnt == GAP_LAST);

    assign uart_out = r_uart;
    assign busy     = r_busy;
    assign done     = r_done;

    // Transmit FSM: bit timing, byte sequencing and registered line/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_uart     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // done is a single-cycle strobe; only the final stop bit raises it.
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_uart <= 1'b1;
                    if (send) begin
                        // The line drops on the accepting edge, so the start bit
                        // occupies the very next cycle.
                        r_shift    <= word_in;
                        r_byte_idx <= '0;
                        r_bit_idx  <= '0;
                        r_clk_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_uart     <= 1'b0;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_uart    <= w_byte[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_uart  <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_uart    <= w_byte[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_byte_idx == 2'd3) begin
                            // Word complete: busy and done change on the same edge.
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_shift    <= {8'h00, r_shift[31:8]};
                            if (GAP_CLKS > 0) begin
                                r_state <= S_GAP;
                            end else begin
                                r_uart  <= 1'b0;
                                r_state <= S_START;
                            end
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    if (w_gap_end) begin
                        r_clk_cnt <= '0;
                        r_uart    <= 1'b0;
                        r_state   <= S_START;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                default: begin
                    r_uart  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
